// File: rtl/z16_dma_pkg.sv
// Shared definitions for the Z16 data-memory copy/fill engine: widths, word stride
// and the transfer state encoding.
package z16_dma_pkg;

  localparam int Z16_ADDR_W  = 16;
  localparam int Z16_DATA_W  = 16;
  localparam int Z16_LEN_W   = 16;
  localparam int WORD_STRIDE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  // The engine owns the memory port only while a word is being moved.
  function automatic logic owns_port(input dma_state_e s);
    return (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/z16_dmem_copy_engine_if.sv
// Control and data-memory bus of the copy engine. The master modport is the engine
// side; the slave modport is the CPU/memory side.
interface z16_dmem_copy_engine_if
  import z16_dma_pkg::*;
#(
  parameter int ADDR_W = Z16_ADDR_W,
  parameter int DATA_W = Z16_DATA_W,
  parameter int LEN_W  = Z16_LEN_W
) ();

  logic              i_start;
  logic              i_mode_fill;
  logic [ADDR_W-1:0] i_src;
  logic [ADDR_W-1:0] i_dst;
  logic [LEN_W-1:0]  i_len;
  logic [DATA_W-1:0] i_fill_data;
  logic              i_abort;
  logic              o_busy;
  logic              o_done;
  logic              o_aborted;
  logic [LEN_W-1:0]  o_words_done;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wen;
  logic [DATA_W-1:0] o_mem_data;
  logic [DATA_W-1:0] i_mem_data;

  modport master (
    input  i_start, i_mode_fill, i_src, i_dst, i_len, i_fill_data, i_abort, i_mem_data,
    output o_busy, o_done, o_aborted, o_words_done, o_mem_addr, o_mem_wen, o_mem_data
  );

  modport slave (
    output i_start, i_mode_fill, i_src, i_dst, i_len, i_fill_data, i_abort, i_mem_data,
    input  o_busy, o_done, o_aborted, o_words_done, o_mem_addr, o_mem_wen, o_mem_data
  );

endinterface

// File: rtl/z16_word_addr_counter.sv
// Word-aligned byte-address register: loads with bit 0 cleared, steps by one word
// and wraps modulo 2^ADDR_W.
module z16_word_addr_counter
  import z16_dma_pkg::*;
#(
  parameter int ADDR_W = Z16_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(WORD_STRIDE);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_addr & ALIGN_MASK;
    end else if (inc) begin
      addr_q <= addr_q + STRIDE;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/z16_dmem_copy_engine.sv
// Block copy (mem->mem) / block fill (const->mem) master for the Z16 data-memory port.
// Copy moves one word per READ+WRITE pair; fill issues back-to-back WRITEs.
module z16_dmem_copy_engine
  import z16_dma_pkg::*;
#(
  parameter int ADDR_W = Z16_ADDR_W,
  parameter int DATA_W = Z16_DATA_W,
  parameter int LEN_W  = Z16_LEN_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  z16_dmem_copy_engine_if.master  bus
);

  dma_state_e state_q, state_d;

  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  words_done_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] fill_q;
  logic              mode_fill_q;
  logic              aborted_q;
  logic              accept;
  logic              set_abort;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  logic              busy_c;
  logic              done_c;
  logic              wen_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign accept = (state_q == ST_IDLE) && bus.i_start;

  z16_word_addr_counter #(.ADDR_W(ADDR_W)) u_src_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (accept),
    .load_addr (bus.i_src),
    .inc       (state_q == ST_READ),
    .addr      (src_addr)
  );

  z16_word_addr_counter #(.ADDR_W(ADDR_W)) u_dst_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (accept),
    .load_addr (bus.i_dst),
    .inc       (state_q == ST_WRITE),
    .addr      (dst_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over continuing; a WRITE presented in the abort cycle still commits.
  always_comb begin
    state_d   = state_q;
    set_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len == '0)    state_d = ST_DONE;
          else if (bus.i_mode_fill) state_d = ST_WRITE;
          else                    state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (bus.i_abort) begin
          state_d   = ST_DONE;
          set_abort = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.i_abort) begin
          state_d   = ST_DONE;
          set_abort = 1'b1;
        end else if (remaining_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end else if (mode_fill_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining_q  <= '0;
      words_done_q <= '0;
      data_q       <= '0;
      fill_q       <= '0;
      mode_fill_q  <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      if (accept) begin
        remaining_q  <= bus.i_len;
        words_done_q <= '0;
        fill_q       <= bus.i_fill_data;
        mode_fill_q  <= bus.i_mode_fill;
        aborted_q    <= 1'b0;
      end
      if (state_q == ST_READ) begin
        data_q <= bus.i_mem_data;
      end
      if (state_q == ST_WRITE) begin
        remaining_q  <= remaining_q - LEN_W'(1);
        words_done_q <= words_done_q + LEN_W'(1);
      end
      if (set_abort) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Port drive is a pure decode of the registered state.
  always_comb begin
    busy_c  = owns_port(state_q);
    done_c  = 1'b0;
    wen_c   = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    unique case (state_q)
      ST_READ: begin
        addr_c = src_addr;
      end
      ST_WRITE: begin
        addr_c  = dst_addr;
        wen_c   = 1'b1;
        wdata_c = mode_fill_q ? fill_q : data_q;
      end
      ST_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        done_c = 1'b0;
      end
    endcase
  end

  assign bus.o_busy       = busy_c;
  assign bus.o_done       = done_c;
  assign bus.o_aborted    = aborted_q;
  assign bus.o_words_done = words_done_q;
  assign bus.o_mem_addr   = addr_c;
  assign bus.o_mem_wen    = wen_c;
  assign bus.o_mem_data   = wdata_c;

endmodule

// File: tb/tb_z16_dmem_copy_engine.sv
// Directed and randomized transfers against a word-array memory model; expected
// writes and timing come from a plain loop model of ascending copy/fill.
module tb_z16_dmem_copy_engine;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z16_dmem_copy_engine_if bus ();

  z16_dmem_copy_engine dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  wr_t         wlog[$];
  wr_t         exp_q[$];
  logic        mem_init = 1'b1;
  logic        pre_we   = 1'b0;
  logic [15:0] pre_a    = '0;
  logic [15:0] pre_d    = '0;
  logic        log_clr  = 1'b0;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h3C5A;
  endfunction

  assign bus.i_mem_data = mem[bus.o_mem_addr[15:1]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
    end else if (pre_we) begin
      mem[pre_a[15:1]] <= pre_d;
    end else if (bus.o_mem_wen) begin
      mem[bus.o_mem_addr[15:1]] <= bus.o_mem_data;
    end
    if (log_clr) wlog.delete();
    else if (bus.o_mem_wen) wlog.push_back('{addr: bus.o_mem_addr, data: bus.o_mem_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a[15:1]] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference: ascending word-by-word transfer on ref_mem; fills exp_q with the writes.
  task automatic model_xfer(input bit mode, input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] fill,
                            input int abort_at, output int n_eff);
    logic [15:0] s, d, v;
    n_eff = (len == 0) ? 0 : ((abort_at > 0) ? abort_at : int'(len));
    exp_q.delete();
    s = src & 16'hFFFE;
    d = dst & 16'hFFFE;
    for (int i = 0; i < n_eff; i++) begin
      v = mode ? fill : ref_mem[s[15:1]];
      ref_mem[d[15:1]] = v;
      exp_q.push_back('{addr: d, data: v});
      s = s + 16'd2;
      d = d + 16'd2;
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), wlog[i].addr, exp_q[i].addr);
      chk($sformatf("%s_wd%0d", tag, i), wlog[i].data, exp_q[i].data);
      chk($sformatf("%s_mem%0d", tag, i), mem[exp_q[i].addr[15:1]], ref_mem[exp_q[i].addr[15:1]]);
    end
  endtask

  task automatic run_xfer(input bit mode, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [15:0] fill,
                          input int abort_at, input bit scramble, input string tag);
    int n_eff, busy_n, wen_n, done_idx, cyc;
    bit seen;
    logic ab;
    logic [15:0] wd;
    model_xfer(mode, src, dst, len, fill, abort_at, n_eff);
    busy_n = 0; wen_n = 0; done_idx = 0; seen = 1'b0; ab = 1'b0; wd = '0;
    @(negedge clk);
    bus.i_mode_fill = mode; bus.i_src = src; bus.i_dst = dst;
    bus.i_len = len; bus.i_fill_data = fill; bus.i_start = 1'b1; log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    bus.i_start = 1'b0;
    cyc = 1;
    while (!seen && cyc <= 600) begin
      if (scramble) begin
        bus.i_start = 1'($urandom); bus.i_mode_fill = 1'($urandom);
        bus.i_src = 16'($urandom); bus.i_dst = 16'($urandom);
        bus.i_len = 16'($urandom); bus.i_fill_data = 16'($urandom);
      end
      if (bus.o_busy) busy_n++;
      if (bus.o_mem_wen) wen_n++;
      bus.i_abort = bus.o_mem_wen && (abort_at > 0) && (wen_n == abort_at);
      if (bus.o_done) begin
        seen = 1'b1; done_idx = cyc; ab = bus.o_aborted; wd = bus.o_words_done;
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, busy_n, mode ? n_eff : 2 * n_eff);
    chk({tag, "_wen_cycles"}, wen_n, n_eff);
    chk({tag, "_done_latency"}, done_idx, (mode ? n_eff : 2 * n_eff) + 1);
    chk({tag, "_aborted"}, ab, (len != 0) && (abort_at > 0));
    chk({tag, "_words_done"}, wd, n_eff);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.o_done, bus.o_busy, bus.o_mem_wen}, 3'b000);
    chk({tag, "_words_hold"}, bus.o_words_done, n_eff);
    check_writes(tag);
  endtask

  initial begin
    int n_eff, wen_n, cyc;
    bit never_done;
    bus.i_start = 1'b0; bus.i_mode_fill = 1'b0; bus.i_src = '0; bus.i_dst = '0;
    bus.i_len = '0; bus.i_fill_data = '0; bus.i_abort = 1'b0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_busy_done", {bus.o_busy, bus.o_done, bus.o_aborted}, 3'b000);
    chk("rst_words", bus.o_words_done, 0);
    chk("rst_mem", {bus.o_mem_addr, bus.o_mem_wen, bus.o_mem_data}, 33'h0);

    // Basic copy
    for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(2 * i), 16'(i + 1));
    run_xfer(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0, 0, 1'b0, "copy4");
    for (int i = 0; i < 4; i++) chk($sformatf("copy4_val%0d", i), mem[16'h0100 + 16'(i)], i + 1);

    run_xfer(1'b1, 16'h0000, 16'h0300, 16'd3, 16'hA5A5, 0, 1'b0, "fill3");
    run_xfer(1'b0, 16'h0101, 16'h0500, 16'd0, 16'h0, 0, 1'b0, "len0");
    run_xfer(1'b1, 16'h0000, 16'h0203, 16'd1, 16'h1234, 0, 1'b0, "odd_dst");
    chk("odd_dst_addr", mem[16'h0101], 16'h1234);
    run_xfer(1'b1, 16'h0000, 16'hFFFE, 16'd2, 16'hBEEF, 0, 1'b0, "wrap");
    chk("wrap_low", mem[16'h0000], 16'hBEEF);

    poke(16'h0010, 16'd7);
    run_xfer(1'b0, 16'h0010, 16'h0012, 16'd3, 16'h0, 0, 1'b0, "smear");
    for (int i = 1; i <= 3; i++) chk($sformatf("smear_val%0d", i), mem[16'h0008 + 16'(i)], 7);

    run_xfer(1'b0, 16'h0400, 16'h0600, 16'd8, 16'h0, 3, 1'b0, "abort");
    run_xfer(1'b1, 16'h0000, 16'h0700, 16'd2, 16'h4242, 0, 1'b0, "post_abort");

    // Reset during a fill, right in the second write cycle
    model_xfer(1'b1, 16'h0000, 16'h0800, 16'd6, 16'h5A5A, 2, n_eff);
    @(negedge clk);
    bus.i_mode_fill = 1'b1; bus.i_dst = 16'h0800; bus.i_len = 16'd6;
    bus.i_fill_data = 16'h5A5A; bus.i_start = 1'b1; log_clr = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; log_clr = 1'b0;
    wen_n = 0; cyc = 0;
    while (wen_n < 2 && cyc < 50) begin
      if (bus.o_mem_wen) wen_n++;
      if (wen_n < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rstmid_reached", wen_n, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_outs", {bus.o_busy, bus.o_done, bus.o_aborted, bus.o_mem_wen}, 4'b0000);
    chk("rstmid_bus", {bus.o_mem_addr, bus.o_mem_data, bus.o_words_done}, 48'h0);
    never_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_done || bus.o_mem_wen) never_done = 1'b0;
    end
    chk("rstmid_quiet", never_done, 1);
    check_writes("rstmid");

    run_xfer(1'b0, 16'h0100, 16'h0900, 16'd4, 16'h0, 0, 1'b0, "after_rst");

    for (int t = 0; t < 24; t++) begin
      logic [15:0] len;
      int ab_at;
      bit mode;
      len   = 16'($urandom_range(0, 7));
      mode  = 1'($urandom);
      ab_at = (len != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(len))) : 0;
      run_xfer(mode, 16'($urandom), 16'($urandom), len, 16'($urandom), ab_at, 1'b1,
               $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
